// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, default latency, counter widths.
package data_memory_responder_pkg;
    localparam logic [1:0]  ST_IDLE         = 2'd0;
    localparam logic [1:0]  ST_ACCESS       = 2'd1;
    localparam logic [1:0]  ST_DONE         = 2'd2;
    localparam int unsigned DEFAULT_LATENCY = 5;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned ACCESS_CNT_W    = 16;
endpackage

// File: rtl/data_memory_responder_array.sv
// Byte-addressed storage: synchronous write and registered read, contents never reset.
module data_mem_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_ff @(posedge CLK) begin
        if (wr_en) mem[addr] <= wdata;
    end

    // Read register holds its value until the next read enable.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) rdata_d = mem[addr];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_memory_responder.sv
// CPU data-memory responder: multi-cycle access FSM driving BUSYWAIT stall.
// Optional DMEM_ACCESS_COUNT_EN adds the saturating ACCESS_CNT completed-access counter.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
`ifdef DMEM_ACCESS_COUNT_EN
    output logic [ACCESS_CNT_W-1:0] ACCESS_CNT,
`endif
    output logic              BUSYWAIT
);
    logic [1:0]        state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              is_write_d, is_write_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              commit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (READ || WRITE) begin
                    is_write_d = WRITE;
                    addr_d     = ADDRESS;
                    data_d     = WRITEDATA;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    commit  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign BUSYWAIT = ((state_q == ST_IDLE) && (READ || WRITE)) || (state_q == ST_ACCESS);

    data_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .CLK   (CLK),
        .RESET (RESET),
        .wr_en (commit && is_write_q),
        .rd_en (commit && !is_write_q),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (READDATA)
    );

`ifdef DMEM_ACCESS_COUNT_EN
    logic [ACCESS_CNT_W-1:0] access_cnt_d, access_cnt_q;

    // Saturating count of committed accesses; aborted ones never reach commit.
    always_comb begin
        access_cnt_d = access_cnt_q;
        if (commit && (access_cnt_q != {ACCESS_CNT_W{1'b1}}))
            access_cnt_d = access_cnt_q + ACCESS_CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) access_cnt_q <= '0;
        else       access_cnt_q <= access_cnt_d;
    end

    assign ACCESS_CNT = access_cnt_q;
`endif
endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios plus randomized accesses
// checked every cycle against a timeline-based reference model.
module tb_data_memory_responder;
`ifdef DMEM_ACCESS_COUNT_EN
    localparam int unsigned L = 1;
`else
    localparam int unsigned L = 5;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       READ, WRITE;
    logic [7:0] ADDRESS, WRITEDATA;
    logic [7:0] READDATA;
    logic       BUSYWAIT;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] ACCESS_CNT;
`endif

    data_memory_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(L)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .READ      (READ),
        .WRITE     (WRITE),
        .ADDRESS   (ADDRESS),
        .WRITEDATA (WRITEDATA),
        .READDATA  (READDATA),
`ifdef DMEM_ACCESS_COUNT_EN
        .ACCESS_CNT(ACCESS_CNT),
`endif
        .BUSYWAIT  (BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request seen while the responder is free occupies windows
    // w..w+L with BUSYWAIT, its result is visible from window w+L+1 (the done window),
    // and the responder is free again from window w+L+2.
    logic [7:0]  m_mem [256];
    logic [7:0]  m_rd;
    logic [15:0] m_cnt;
    int          w = 0;
    int          busy_end = 0, t_free = 0, pend_vis = 0;
    bit          pend = 0, p_wr = 0;
    logic [7:0]  p_a, p_d;

    always @(negedge CLK) begin
        bit start;
        #1;
        w++;
        if (RESET) begin
            pend = 0; busy_end = 0; t_free = w; m_rd = 8'h00; m_cnt = 16'h0;
            chk("reset_busywait", 32'(BUSYWAIT), 32'd0);
            chk("reset_readdata", 32'(READDATA), 32'd0);
`ifdef DMEM_ACCESS_COUNT_EN
            chk("reset_access_cnt", 32'(ACCESS_CNT), 32'd0);
`endif
        end else begin
            if (pend && w == pend_vis) begin
                if (p_wr) m_mem[p_a] = p_d;
                else      m_rd = m_mem[p_a];
                if (m_cnt != 16'hFFFF) m_cnt++;
                pend = 0;
            end
            start = (READ || WRITE) && (w >= t_free);
            chk("busywait", 32'(BUSYWAIT), 32'((w < busy_end) || start));
            chk("readdata", 32'(READDATA), 32'(m_rd));
`ifdef DMEM_ACCESS_COUNT_EN
            chk("access_cnt", 32'(ACCESS_CNT), 32'(m_cnt));
`endif
            if (start) begin
                pend = 1; pend_vis = w + L + 1; busy_end = w + L + 1; t_free = w + L + 2;
                p_wr = WRITE; p_a = ADDRESS; p_d = WRITEDATA;
            end
        end
    end

    // One CPU access: hold the request until BUSYWAIT falls, optionally disturbing inputs
    // or aborting with RESET after a given number of stalled windows.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input int scramble_at, input int abort_at);
        int n_busy = 0;
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
        #2;
        if (BUSYWAIT) n_busy = 1;
        for (int i = 0; i < 40; i++) begin
            if (!BUSYWAIT) break;
            if (abort_at != 0 && n_busy == abort_at) begin
                RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
                #1;
                chk("abort_busywait", 32'(BUSYWAIT), 32'd0);
                chk("abort_readdata", 32'(READDATA), 32'd0);
                @(negedge CLK); #3;
                RESET = 1'b0;
                return;
            end
            if (scramble_at != 0 && n_busy == scramble_at) begin
                ADDRESS = 8'h21; WRITEDATA = 8'hFF;
            end
            @(negedge CLK); #2;
            if (BUSYWAIT) n_busy++;
        end
        if (BUSYWAIT) chk("busywait_timeout", 32'(BUSYWAIT), 32'd0);
        chk("busy_cycles", 32'(n_busy), 32'(L + 1));
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        repeat (3) @(negedge CLK);
        #3 RESET = 1'b0;

        access(1'b0, 1'b1, 8'h21, 8'h99, 0, 0);
        access(1'b0, 1'b1, 8'h05, 8'h11, 0, 0);

        access(1'b0, 1'b1, 8'h10, 8'hA5, 0, 0);
        access(1'b1, 1'b0, 8'h10, 8'h00, 0, 0);
        chk("read_10", 32'(READDATA), 32'hA5);

        access(1'b0, 1'b1, 8'h20, 8'h3C, 2, 0);
        access(1'b1, 1'b0, 8'h20, 8'h00, 0, 0);
        chk("read_20", 32'(READDATA), 32'h3C);
        access(1'b1, 1'b0, 8'h21, 8'h00, 0, 0);
        chk("read_21", 32'(READDATA), 32'h99);

        access(1'b0, 1'b1, 8'h05, 8'h77, 0, (L >= 3) ? 4 : 1);
        access(1'b1, 1'b0, 8'h05, 8'h00, 0, 0);
        chk("read_05_after_abort", 32'(READDATA), 32'h11);

        access(1'b1, 1'b1, 8'h40, 8'h5A, 0, 0);
        chk("rw_keeps_readdata", 32'(READDATA), 32'h11);
        access(1'b1, 1'b0, 8'h40, 8'h00, 0, 0);
        chk("read_40", 32'(READDATA), 32'h5A);

`ifdef DMEM_ACCESS_COUNT_EN
        @(negedge CLK); #3 RESET = 1'b1;
        @(negedge CLK); #3 RESET = 1'b0;
        for (int i = 0; i < 3; i++) access(1'b0, 1'b1, 8'(8'h60 + i), 8'(i), 0, 0);
        chk("access_cnt_3", 32'(ACCESS_CNT), 32'd3);
        #1 RESET = 1'b1;
        #1 chk("access_cnt_reset", 32'(ACCESS_CNT), 32'd0);
        @(negedge CLK); #3 RESET = 1'b0;
`endif

        for (int i = 0; i < 8; i++) access(1'b0, 1'b1, 8'(8'h80 + i), 8'($urandom), 0, 0);
        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            access(op != 1, op != 0, 8'(8'h80 + $urandom_range(0, 7)), 8'($urandom), 0, 0);
        end

        repeat (4) @(negedge CLK);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
